// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: RV32M/RV64M multiply/divide unit, one operation in flight.
//   Multiply: (XLEN+1)-bit sign/zero-extended operands, product through a MUL_LAT-deep
//   register chain (the result register is the last stage).
//   Divide: radix-2 restoring divider, XLEN iterations on magnitudes, then a sign fix-up cycle.
//   Divide by zero and signed overflow are resolved at accept with no iterations.
// Optional: define MULDIV_DIV_CACHE_EN to add a single-entry cache of the last completed
//   normal division {op_a, op_b, unsigned-flag, quotient, remainder}; a matching divide or
//   remainder returns the cached value with latency 1 (DIV-then-REM fusion).
// Ports:
//   clk_i, rst_i (synchronous, active high)
//   valid_i/ready_o, funct3_i, op_a_i, op_b_i, tag_i  request side
//   flush_i                                           abort in-flight op, drop result
//   valid_o/ready_i, result_o, tag_o                  result side
//   busy_o                                            unit not idle
module muldiv_iter_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  op_a_i,
    input  logic [XLEN-1:0]  op_b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int unsigned     CntW    = $clog2(XLEN) + 1;
    localparam int unsigned     PipeD   = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    // One restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor if that does not borrow. The dividend shifts out of the top of
    // quo while quotient bits shift in at the bottom. Returns {rem, quo}.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0]   tmp;
        logic [XLEN+1:0] diff;
        logic            qbit;
        logic [XLEN-1:0] nrem;
        tmp  = {rem, quo[XLEN-1]};
        diff = {1'b0, tmp} - {2'b00, dvs};
        qbit = ~diff[XLEN+1];
        // Both candidates are below dvs, so the top bit is always zero.
        nrem = qbit ? diff[XLEN-1:0] : tmp[XLEN-1:0];
        return {nrem, quo[XLEN-2:0], qbit};
    endfunction

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  pipe_q [PipeD];
    logic [XLEN-1:0]  pipe_d [PipeD];
    logic [XLEN-1:0]  result_q, result_d;
    logic             valid_q, valid_d;

    logic                    accept;
    logic signed [XLEN:0]    mul_a, mul_b;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0]         mul_res;
    logic                    div_sgn, a_neg, b_neg;
    logic [XLEN-1:0]         a_mag, b_mag;
    logic                    div_zero, div_ovf;
    logic [XLEN-1:0]         special_res;
    logic [2*XLEN-1:0]       first_step, iter_step;
    logic [XLEN-1:0]         quo_fix, rem_fix;
    logic                    cache_hit;
    logic [XLEN-1:0]         cache_res;

    assign accept = valid_i & (state_q == StIdle) & ~flush_i;

    // MUL/MULH: s x s, MULHSU: s x u, MULHU: u x u.
    assign mul_a   = {(funct3_i[1:0] != 2'b11) & op_a_i[XLEN-1], op_a_i};
    assign mul_b   = {~funct3_i[1] & op_b_i[XLEN-1], op_b_i};
    assign prod    = mul_a * mul_b;
    assign mul_res = (funct3_i[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign div_sgn     = ~funct3_i[0];
    assign a_neg       = div_sgn & op_a_i[XLEN-1];
    assign b_neg       = div_sgn & op_b_i[XLEN-1];
    assign a_mag       = a_neg ? -op_a_i : op_a_i;
    assign b_mag       = b_neg ? -op_b_i : op_b_i;
    assign div_zero    = (op_b_i == '0);
    assign div_ovf     = div_sgn & (op_a_i == MinInt) & (op_b_i == '1);
    assign special_res = div_zero ? (funct3_i[1] ? op_a_i : '1)
                                  : (funct3_i[1] ? '0 : MinInt);

    // The first iteration is taken on the accept edge.
    assign first_step = div_step('0, a_mag, b_mag);
    assign iter_step  = div_step(rem_q, quo_q, dvs_q);
    assign quo_fix    = qneg_q ? -quo_q : quo_q;
    assign rem_fix    = rneg_q ? -rem_q : rem_q;

`ifdef MULDIV_DIV_CACHE_EN
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            cv_q, cv_d;
    logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d;
    logic            cu_q, cu_d;
    logic [XLEN-1:0] cquo_q, cquo_d, crem_q, crem_d;

    assign cache_hit = cv_q & (ca_q == op_a_i) & (cb_q == op_b_i) & (cu_q == funct3_i[0]);
    assign cache_res = funct3_i[1] ? crem_q : cquo_q;
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        tag_d    = tag_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        valid_d  = valid_q;
`ifdef MULDIV_DIV_CACHE_EN
        a_d    = a_q;
        b_d    = b_q;
        cv_d   = cv_q;
        ca_d   = ca_q;
        cb_d   = cb_q;
        cu_d   = cu_q;
        cquo_d = cquo_q;
        crem_d = crem_q;
`endif
        pipe_d[0] = accept ? mul_res : pipe_q[0];
        for (int i = 1; i < int'(PipeD); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    f3_d  = funct3_i;
                    tag_d = tag_i;
                    if (!funct3_i[2]) begin
                        if (MUL_LAT == 1) begin
                            result_d = mul_res;
                            valid_d  = 1'b1;
                            state_d  = StDone;
                        end else begin
                            cnt_d   = CntW'(1);
                            state_d = StMul;
                        end
                    end else if (div_zero || div_ovf) begin
                        result_d = special_res;
                        valid_d  = 1'b1;
                        state_d  = StDone;
                    end else if (cache_hit) begin
                        result_d = cache_res;
                        valid_d  = 1'b1;
                        state_d  = StDone;
                    end else begin
                        {rem_d, quo_d} = first_step;
                        dvs_d   = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = CntW'(1);
                        state_d = StDiv;
`ifdef MULDIV_DIV_CACHE_EN
                        a_d = op_a_i;
                        b_d = op_b_i;
`endif
                    end
                end
            end
            StMul: begin
                if (cnt_q == MulLast) begin
                    result_d = pipe_q[PipeD-1];
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDiv: begin
                {rem_d, quo_d} = iter_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DivLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = f3_q[1] ? rem_fix : quo_fix;
                valid_d  = 1'b1;
                state_d  = StDone;
`ifdef MULDIV_DIV_CACHE_EN
                if (!flush_i) begin
                    cv_d   = 1'b1;
                    ca_d   = a_q;
                    cb_d   = b_q;
                    cu_d   = f3_q[0];
                    cquo_d = quo_fix;
                    crem_d = rem_fix;
                end
`endif
            end
            StDone: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // Flush beats everything, including ready_i in StDone.
        if (flush_i && (state_q != StIdle)) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            f3_q     <= '0;
            tag_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < int'(PipeD); i++) begin
                pipe_q[i] <= '0;
            end
`ifdef MULDIV_DIV_CACHE_EN
            a_q    <= '0;
            b_q    <= '0;
            cv_q   <= 1'b0;
            ca_q   <= '0;
            cb_q   <= '0;
            cu_q   <= 1'b0;
            cquo_q <= '0;
            crem_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            tag_q    <= tag_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            pipe_q   <= pipe_d;
`ifdef MULDIV_DIV_CACHE_EN
            a_q    <= a_d;
            b_q    <= b_d;
            cv_q   <= cv_d;
            ca_q   <= ca_d;
            cb_q   <= cb_d;
            cu_q   <= cu_d;
            cquo_q <= cquo_d;
            crem_q <= crem_d;
`endif
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign busy_o   = (state_q != StIdle);
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit (XLEN=32, MUL_LAT=2).
// Expected results come from plain SystemVerilog arithmetic; expected latencies from the
// operation class plus a model of the optional division cache.
module tb_muldiv_iter_unit;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;
    localparam int DIV_LAT = XLEN + 1;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [2:0]       funct3_i = '0;
    logic [XLEN-1:0]  op_a_i = '0;
    logic [XLEN-1:0]  op_b_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             flush_i = 1'b0;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    int errors = 0;
    int checks = 0;

    // Model of the division cache.
    bit        mc_v = 1'b0;
    bit [31:0] mc_a, mc_b;
    bit        mc_u;

    muldiv_iter_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .tag_o(tag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        int sa, sb;
        if (!f[2]) begin
            ea = (f[1:0] != 2'b11) ? {{34{a[31]}}, a} : {34'b0, a};
            eb = (f[1:0] <= 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
            p  = ea * eb;
            return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic int exp_lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (is_special(f, a, b)) return 1;
`ifdef MULDIV_DIV_CACHE_EN
        if (mc_v && mc_a == a && mc_b == b && mc_u == f[0]) return 1;
`endif
        return DIV_LAT;
    endfunction

    task automatic model_commit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && !is_special(f, a, b)) begin
            mc_v = 1'b1;
            mc_a = a;
            mc_b = b;
            mc_u = f[0];
        end
    endtask

    // Issue one op at a negedge with the unit idle; returns at the negedge after the result
    // is consumed (or, with ready_i low, at the first negedge showing valid_o).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, output logic [31:0] res,
                          output logic [4:0] tout, output int lat);
        valid_i  = 1'b1;
        funct3_i = f;
        op_a_i   = a;
        op_b_i   = b;
        tag_i    = tg;
        @(posedge clk);
        @(negedge clk);
        valid_i  = 1'b0;
        funct3_i = 3'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        tag_i    = 5'($urandom);
        lat = 1;
        while (valid_o !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res  = result_o;
        tout = tag_o;
        if (ready_i) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [4:0]  t;
        int          lat;
        bit          seen;
        rst_i   = 1'b1;
        valid_i = 1'b1;
        funct3_i = 3'b000;
        op_a_i  = 32'h1234;
        op_b_i  = 32'h5678;
        tag_i   = 5'd9;
        repeat (3) @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
        checks++; if (tag_o !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", tag_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        valid_i = 1'b0;
        rst_i   = 1'b0;
        @(negedge clk);
        // Reset in the middle of a divide drops it.
        valid_i = 1'b1; funct3_i = 3'b101; op_a_i = 32'd100; op_b_i = 32'd7; tag_i = 5'd4;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_midop_idle: got ready=%b busy=%b expected ready=1 busy=0", ready_o, busy_o); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (valid_o === 1'b1) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_midop_novalid: got valid seen=%b expected 0", seen); end
        mc_v = 1'b0;
        // Unit still usable after the mid-op reset.
        run_op(3'b101, 32'd100, 32'd7, 5'd4, r, t, lat);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL reset_after_op: got %h expected %h", r, 32'd14); end
        model_commit(3'b101, 32'd100, 32'd7);
    endtask

    task automatic test_mul();
        logic [2:0]  fs [4]  = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [31:0] es [4]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] r, a, b, er;
        logic [4:0]  t, tg;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, r, t, lat);
            checks++; if (r !== es[i]) begin errors++; $display("FAIL mul_dir_result[%0d]: got %h expected %h", i, r, es[i]); end
            checks++; if (t !== 5'd3) begin errors++; $display("FAIL mul_dir_tag[%0d]: got %0d expected 3", i, t); end
            checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_dir_lat[%0d]: got %0d expected %0d", i, lat, MUL_LAT); end
        end
        for (int i = 0; i < 24; i++) begin
            f  = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 0) a = 32'h8000_0000;
            if (i % 6 == 1) b = 32'hFFFF_FFFF;
            if (i % 6 == 2) b = $urandom_range(0, 3);
            tg = 5'($urandom);
            er = ref_result(f, a, b);
            run_op(f, a, b, tg, r, t, lat);
            checks++; if (r !== er) begin errors++; $display("FAIL mul_rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, er); end
            checks++; if (t !== tg || lat !== MUL_LAT) begin errors++; $display("FAIL mul_rand_tag_lat[%0d]: got tag=%0d lat=%0d expected tag=%0d lat=%0d", i, t, lat, tg, MUL_LAT); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] es [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r, a, b, er;
        logic [4:0]  t, tg;
        logic [2:0]  f;
        int          lat, el;
        for (int i = 0; i < 4; i++) begin
            el = exp_lat(fs[i], as[i], bs[i]);
            tg = 5'(i + 10);
            run_op(fs[i], as[i], bs[i], tg, r, t, lat);
            checks++; if (r !== es[i]) begin errors++; $display("FAIL div_dir_result[%0d]: got %h expected %h", i, r, es[i]); end
            checks++; if (t !== tg) begin errors++; $display("FAIL div_dir_tag[%0d]: got %0d expected %0d", i, t, tg); end
            checks++; if (lat !== el) begin errors++; $display("FAIL div_dir_lat[%0d]: got %0d expected %0d", i, lat, el); end
            model_commit(fs[i], as[i], bs[i]);
        end
        a = 32'd1; b = 32'd1;
        for (int i = 0; i < 30; i++) begin
            f = 3'b100 | 3'($urandom_range(0, 3));
            if (i % 5 != 4) begin
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 5))
                    0: b = $urandom_range(1, 15);
                    1: b = 32'h0;
                    2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    3: b = b >> $urandom_range(0, 31);
                    default: ;
                endcase
            end
            tg = 5'($urandom);
            er = ref_result(f, a, b);
            el = exp_lat(f, a, b);
            run_op(f, a, b, tg, r, t, lat);
            checks++; if (r !== er) begin errors++; $display("FAIL div_rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, er); end
            checks++; if (t !== tg || lat !== el) begin errors++; $display("FAIL div_rand_tag_lat[%0d]: got tag=%0d lat=%0d expected tag=%0d lat=%0d", i, t, lat, tg, el); end
            model_commit(f, a, b);
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b110};
        logic [31:0] as [4] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        logic [31:0] bs [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] es [4] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] r;
        logic [4:0]  t;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], 5'(20 + i), r, t, lat);
            checks++; if (r !== es[i]) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, es[i]); end
            checks++; if (lat !== 1 || t !== 5'(20 + i)) begin errors++; $display("FAIL special_lat_tag[%0d]: got lat=%0d tag=%0d expected lat=1 tag=%0d", i, lat, t, 20 + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, r2;
        logic [4:0]  t, t2;
        int          lat;
        ready_i = 1'b0;
        run_op(3'b000, 32'd1234, 32'd5678, 5'd17, r, t, lat);
        checks++; if (r !== 32'd7006652 || t !== 5'd17) begin errors++; $display("FAIL bp_result: got %h tag=%0d expected %h tag=17", r, t, 32'd7006652); end
        for (int i = 0; i < 10; i++) begin
            valid_i  = 1'b1;
            funct3_i = 3'($urandom);
            op_a_i   = $urandom;
            op_b_i   = $urandom;
            tag_i    = 5'($urandom);
            @(negedge clk);
            checks++;
            if (result_o !== r || tag_o !== t || ready_o !== 1'b0 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got res=%h tag=%0d ready=%b valid=%b expected res=%h tag=%0d ready=0 valid=1",
                         i, result_o, tag_o, ready_o, valid_o, r, t);
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, r2, t2, lat);
        checks++; if (r2 !== 32'hFFFF_FFFE || t2 !== 5'd6) begin errors++; $display("FAIL bp_next_op: got %h tag=%0d expected fffffffe tag=6", r2, t2); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        logic [4:0]  t;
        int          lat, el;
        bit          seen;
        valid_i = 1'b1; funct3_i = 3'b100; op_a_i = 32'd987654; op_b_i = 32'd321; tag_i = 5'd8;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL flush_div_idle: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (valid_o === 1'b1) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_div_novalid: got valid seen=%b expected 0", seen); end
        // Flushed divide must not have filled the cache.
        el = exp_lat(3'b100, 32'd987654, 32'd321);
        run_op(3'b100, 32'd987654, 32'd321, 5'd8, r, t, lat);
        checks++; if (r !== 32'd3076 || lat !== el) begin errors++; $display("FAIL flush_div_rerun: got %0d lat=%0d expected 3076 lat=%0d", r, lat, el); end
        model_commit(3'b100, 32'd987654, 32'd321);
        // Flush together with a request in idle: nothing accepted.
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd3; op_b_i = 32'd3;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL flush_idle_block: got busy=%b ready=%b expected busy=0 ready=1", busy_o, ready_o); end
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (valid_o === 1'b1) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_novalid: got valid seen=%b expected 0", seen); end
        // Flush beats ready_i in the result state.
        ready_i = 1'b0;
        run_op(3'b000, 32'd6, 32'd7, 5'd2, r, t, lat);
        flush_i = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL flush_done: got valid=%b ready=%b expected valid=0 ready=1", valid_o, ready_o); end
    endtask

    task automatic test_cache();
        logic [31:0] r;
        logic [4:0]  t;
        int          lat, el;
        el = exp_lat(3'b100, 32'd1000, 32'd7);
        run_op(3'b100, 32'd1000, 32'd7, 5'd1, r, t, lat);
        checks++; if (r !== 32'd142 || lat !== el) begin errors++; $display("FAIL cache_div: got %0d lat=%0d expected 142 lat=%0d", r, lat, el); end
        model_commit(3'b100, 32'd1000, 32'd7);
        el = exp_lat(3'b110, 32'd1000, 32'd7);
`ifdef MULDIV_DIV_CACHE_EN
        checks++; if (el !== 1) begin errors++; $display("FAIL cache_model_hit: got %0d expected 1", el); end
`endif
        run_op(3'b110, 32'd1000, 32'd7, 5'd2, r, t, lat);
        checks++; if (r !== 32'd6 || lat !== el || t !== 5'd2) begin errors++; $display("FAIL cache_rem: got %0d lat=%0d tag=%0d expected 6 lat=%0d tag=2", r, lat, t, el); end
        model_commit(3'b110, 32'd1000, 32'd7);
        run_op(3'b111, 32'd1000, 32'd7, 5'd3, r, t, lat);
        checks++; if (r !== 32'd6 || lat !== DIV_LAT) begin errors++; $display("FAIL cache_remu: got %0d lat=%0d expected 6 lat=%0d", r, lat, DIV_LAT); end
        model_commit(3'b111, 32'd1000, 32'd7);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, a, b, er;
        logic [4:0]  t, tg;
        logic [2:0]  f;
        int          lat, el;
        for (int i = 0; i < 30; i++) begin
            f  = 3'($urandom);
            a  = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            tg = 5'($urandom);
            er = ref_result(f, a, b);
            el = exp_lat(f, a, b);
            run_op(f, a, b, tg, r, t, lat);
            checks++; if (r !== er) begin errors++; $display("FAIL b2b_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, er); end
            checks++; if (t !== tg || lat !== el) begin errors++; $display("FAIL b2b_tag_lat[%0d]: got tag=%0d lat=%0d expected tag=%0d lat=%0d", i, t, lat, tg, el); end
            model_commit(f, a, b);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_cache();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised RV32M/RV64M multiply/divide unit. It replaces the fixed 2/3-stage vendor-IP unit with a self-contained design: a configurable-latency multiplier plus a radix-2 restoring divider.
- Handles one operation at a time, with a valid/ready handshake on both input and output, a tag passthrough and a pipeline flush.
- Sits beside the ALU in EX; the core stalls on ready_o/valid_o instead of counting fixed stages.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_LAT, 2, multiply latency in cycles from accept to valid_o (1..4)
TAG_W, 5, width of the opaque tag (rd index) carried with the op

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  request valid
ready_o  out  1  unit can accept a request
funct3_i  in  3  M-extension funct3 (MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111)
op_a_i  in  XLEN  rs1
op_b_i  in  XLEN  rs2
tag_i  in  TAG_W  tag accompanying request
flush_i  in  1  abort in-flight op, discard result
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  XLEN  result
tag_o  out  TAG_W  tag of the result
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i sampled high at posedge): state=IDLE, valid_o=0, result_o=0, tag_o=0, busy_o=0, ready_o=1, cache valid bit cleared. Reset mid-operation drops the op with no output.
- Accept = valid_i & ready_o & ~flush_i at posedge.
- ready_o = (state==IDLE). The unit is non-pipelined: one op in flight.
- Operands, funct3 and tag are latched on accept; input changes afterwards are ignored.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on accept of funct3[2]=0.
  - IDLE -> DIV on accept of funct3[2]=1, normal case.
  - IDLE -> DONE on accept of a divide special case.
  - MUL -> DONE after MUL_LAT-1 cycles in MUL. The product is formed from 33-bit (XLEN+1) sign/zero-extended operands: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned. It is registered through a MUL_LAT-deep delay line so synthesis can retime.
  - DIV -> FIX after exactly XLEN iterations. Each iteration shifts one dividend bit into the partial remainder and subtracts the divisor magnitude if no borrow. Operands are magnitudes for DIV/REM, raw values for DIVU/REMU.
  - FIX -> DONE. Applies signs: quotient negated iff sign(a)^sign(b) (signed ops), remainder takes sign of a.
  - DONE -> IDLE when ready_i=1. valid_o=1, result_o and tag_o are stable throughout DONE.
- Latency, accept edge to first valid_o cycle:
  - MUL*: MUL_LAT.
  - DIV*/REM*: XLEN+1.
  - Special case or cache hit: 1.
- Special cases, resolved in IDLE, no iterations:
  - divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - signed overflow (a = MIN_INT, b = -1): DIV -> MIN_INT; REM -> 0.
- Width rules: MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN]. All arithmetic is internal at XLEN+1 or 2XLEN+2 bits; no truncation before selection.
- Flush:
  - flush_i=1 in any non-IDLE state -> IDLE next cycle, valid_o=0 next cycle, result lost, the cache is not written.
  - flush_i in IDLE blocks accept that cycle.
  - flush_i has priority over ready_i in DONE.
- Back-pressure: DONE holds indefinitely while ready_i=0; no new accept until the result is consumed.

Optional Feature:
- Macro: MULDIV_DIV_CACHE_EN.
- Defined: a single-entry cache holds {op_a, op_b, signedness, quotient, remainder} from the last completed normal division, written in FIX.
  - An accepted DIV/DIVU/REM/REMU whose op_a, op_b and signedness (funct3[0]) match a valid entry goes IDLE -> DONE with the cached quotient or remainder: latency 1.
  - This covers the DIV-then-REM fusion case.
  - The cache is cleared by reset only.
- Undefined: no cache storage; every normal division takes XLEN+1 cycles.

Test Plan:
- XLEN=32, MUL_LAT=2: MUL a=0xFFFFFFFF b=0x00000002 tag=3 -> valid_o at cycle 2, result_o=0xFFFFFFFE, tag_o=3. MULH same operands -> 0xFFFFFFFF. MULHU -> 0x00000001. MULHSU -> 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9) b=2 -> valid_o at cycle 33, result_o=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14, REMU -> 2.
- Special cases, each with valid_o at cycle 1:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
- Back-pressure: hold ready_i=0 for 10 cycles after valid_o -> result_o/tag_o unchanged, ready_o=0, valid_i ignored. ready_i=1 -> IDLE, then the next op is accepted.
- Flush: flush_i at cycle 10 of a DIV -> valid_o never asserts, ready_o=1 at cycle 11. Flush in the same cycle as valid_i in IDLE -> op not accepted.
- MULDIV_DIV_CACHE_EN: DIV 1000/7 (33 cycles) then REM 1000/7 -> result 6 at latency 1. Then REMU 1000/7 (signedness differs) -> latency 33.
